seq_div16: RTL and testbench



---
 rtl/div_pkg.sv | 15 +
 rtl/sub16_cla.sv | 57 +++++
 rtl/seq_div16.sv | 170 +++++++++++++++++
 tb/tb_seq_div16.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the seq_div16 iterative divider.
// Holds the state encoding, datapath width and divide-by-zero quotient.
package div_pkg;

    localparam int DIV_WIDTH = 16;
    localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } div_state_e;

endpackage

// File: rtl/sub16_cla.sv
// 16-bit subtractor S = A - B built on a two-level carry-lookahead adder.
// Cout=1 means no borrow, i.e. A >= B when both are read as unsigned.
module sub16_cla (
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [15:0] S,
    output logic        Cout
);

    logic [15:0] bn;
    logic [15:0] g;
    logic [15:0] p;
    logic [16:0] c;
    logic [3:0]  gg;
    logic [3:0]  gp;
    logic [4:0]  gc;

    assign bn = ~B;
    assign g  = A & bn;
    assign p  = A ^ bn;

    // Group generate/propagate per nibble, then lookahead across the four groups with Cin=1.
    always_comb begin
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        for (int i = 0; i < 4; i++) begin
            gg[i] = g[4*i+3]
                  | (p[4*i+3] & g[4*i+2])
                  | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                  | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
            gp[i] = &p[4*i +: 4];
        end
        gc[0] = 1'b1;
        gc[1] = gg[0] | (gp[0] & gc[0]);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & gc[0]);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & gc[0]);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & gc[0]);
        for (int i = 0; i < 4; i++) begin
            c[4*i]   = gc[i];
            c[4*i+1] = g[4*i] | (p[4*i] & gc[i]);
            c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i]) | (p[4*i+1] & p[4*i] & gc[i]);
            c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1])
                     | (p[4*i+2] & p[4*i+1] & g[4*i])
                     | (p[4*i+2] & p[4*i+1] & p[4*i] & gc[i]);
        end
        c[16] = gc[4];
    end

    assign S    = p ^ c[15:0];
    assign Cout = c[16];

endmodule

// File: rtl/seq_div16.sv
// Iterative 16-bit restoring divider, one quotient bit per cycle over 16 cycles.
// Define DIV_SIGNED_EN to add the signed_op port and the FIX sign-correction state.
module seq_div16
    import div_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ITERS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
    input  logic             signed_op,
`endif
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    div_state_e state, next_state;

    logic [DIV_WIDTH-1:0] d_q, q_q, r_q;
    logic [3:0]           cnt;
    logic                 div_zero_q;
    logic [DIV_WIDTH-1:0] shift;
    logic [DIV_WIDTH-1:0] sub_a, sub_b, sub_s;
    logic                 sub_cout;
    logic                 take;
    logic                 accept;
    logic                 last_iter;

`ifdef DIV_SIGNED_EN
    logic                 signed_q, q_neg, r_neg;
    logic [DIV_WIDTH-1:0] neg_b, neg_s;
    logic                 neg_cout;
`endif

    assign accept    = start && (state == IDLE);
    assign last_iter = (cnt == 4'(ITERS - 1));
    assign shift     = {r_q[14:0], q_q[15]};
    // R[15] set means the shifted remainder overflowed 16 bits, so it is certainly >= D.
    assign take      = r_q[15] | sub_cout;

    // The trial subtractor doubles as the dividend negator in IDLE and the quotient negator in FIX.
    always_comb begin
        sub_a = shift;
        sub_b = d_q;
`ifdef DIV_SIGNED_EN
        neg_b = r_q;
        if (state == IDLE) begin
            sub_a = '0;
            sub_b = dividend;
            neg_b = divisor;
        end else if (state == FIX) begin
            sub_a = '0;
            sub_b = q_q;
        end
`endif
    end

    sub16_cla u_sub (
        .A    (sub_a),
        .B    (sub_b),
        .S    (sub_s),
        .Cout (sub_cout)
    );

`ifdef DIV_SIGNED_EN
    sub16_cla u_neg (
        .A    ('0),
        .B    (neg_b),
        .S    (neg_s),
        .Cout (neg_cout)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) next_state = (divisor == '0) ? DONE : RUN;
            end
            RUN: begin
                if (last_iter) begin
`ifdef DIV_SIGNED_EN
                    next_state = signed_q ? FIX : DONE;
`else
                    next_state = DONE;
`endif
                end
            end
            FIX:     next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q        <= '0;
            q_q        <= '0;
            r_q        <= '0;
            cnt        <= '0;
            div_zero_q <= 1'b0;
`ifdef DIV_SIGNED_EN
            signed_q   <= 1'b0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt <= '0;
                        d_q <= divisor;
`ifdef DIV_SIGNED_EN
                        signed_q <= signed_op;
                        q_neg    <= signed_op & (dividend[15] ^ divisor[15]);
                        r_neg    <= signed_op & dividend[15];
`endif
                        if (divisor == '0) begin
                            q_q        <= DIV0_QUOTIENT;
                            r_q        <= dividend;
                            div_zero_q <= 1'b1;
                        end else begin
                            q_q        <= dividend;
                            r_q        <= '0;
                            div_zero_q <= 1'b0;
`ifdef DIV_SIGNED_EN
                            if (signed_op) begin
                                q_q <= dividend[15] ? sub_s : dividend;
                                d_q <= divisor[15] ? neg_s : divisor;
                            end
`endif
                        end
                    end
                end
                RUN: begin
                    r_q <= take ? sub_s : shift;
                    q_q <= {q_q[14:0], take};
                    cnt <= cnt + 4'd1;
                end
                FIX: begin
`ifdef DIV_SIGNED_EN
                    if (q_neg) q_q <= sub_s;
                    if (r_neg) r_q <= neg_s;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign ready     = (state == IDLE);
    assign done      = (state == DONE);
    assign quotient  = q_q;
    assign remainder = r_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_div16.sv
// Directed self-checking bench for seq_div16 with hand-computed results.
// Signed scenarios are compiled in when DIV_SIGNED_EN is defined.
module tb_seq_div16;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
`ifdef DIV_SIGNED_EN
    logic        signed_op;
`endif
    logic        ready;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_zero;

    int tests;
    int fails;

    seq_div16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
`ifdef DIV_SIGNED_EN
        .signed_op (signed_op),
`endif
        .ready     (ready),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one edge; returns at the negedge right after the accepting edge.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 16'h5A5A;
        divisor  = 16'hA5A5;
    endtask

    // Cycles (negedges) from the one after the accepting edge until done is seen; 40 on timeout.
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        tests++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_handshake ready=%b done=%b expected ready=1 done=0", ready, done);
        end
        tests++;
        if (quotient !== 16'h0 || remainder !== 16'h0 || div_zero !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_results q=%h r=%h dz=%b expected 0000 0000 0", quotient, remainder, div_zero);
        end
    endtask

    task automatic test_basic();
        int lat;
        start_op(16'd100, 16'd7);
        tests++;
        if (ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL basic_busy ready=%b expected 0", ready);
        end
        wait_done(lat);
        tests++;
        if (lat !== 16) begin
            fails++;
            $display("[TB] FAIL basic_latency got=%0d expected 16", lat);
        end
        tests++;
        if (quotient !== 16'd14 || remainder !== 16'd2) begin
            fails++;
            $display("[TB] FAIL basic_100_7 q=%0d r=%0d expected 14 2", quotient, remainder);
        end
        @(negedge clk);
        tests++;
        if (done !== 1'b0 || ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL basic_after_done done=%b ready=%b expected 0 1", done, ready);
        end
    endtask

    task automatic test_boundaries();
        int lat;
        start_op(16'hFFFF, 16'h0001);
        wait_done(lat);
        tests++;
        if (lat !== 16 || quotient !== 16'hFFFF || remainder !== 16'h0000) begin
            fails++;
            $display("[TB] FAIL ffff_div_1 lat=%0d q=%h r=%h expected 16 ffff 0000", lat, quotient, remainder);
        end
        start_op(16'h8001, 16'h8000);
        wait_done(lat);
        tests++;
        if (quotient !== 16'h0001 || remainder !== 16'h0001) begin
            fails++;
            $display("[TB] FAIL r15_take q=%h r=%h expected 0001 0001", quotient, remainder);
        end
        start_op(16'hFFFE, 16'hFFFF);
        wait_done(lat);
        tests++;
        if (quotient !== 16'h0000 || remainder !== 16'hFFFE) begin
            fails++;
            $display("[TB] FAIL small_quotient q=%h r=%h expected 0000 fffe", quotient, remainder);
        end
    endtask

    task automatic test_div_zero();
        int lat;
        start_op(16'd1234, 16'd0);
        wait_done(lat);
        tests++;
        if (lat !== 0) begin
            fails++;
            $display("[TB] FAIL div0_latency got=%0d expected 0", lat);
        end
        tests++;
        if (quotient !== 16'hFFFF || remainder !== 16'd1234 || div_zero !== 1'b1) begin
            fails++;
            $display("[TB] FAIL div0_result q=%h r=%0d dz=%b expected ffff 1234 1", quotient, remainder, div_zero);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (quotient !== 16'hFFFF || remainder !== 16'd1234 || div_zero !== 1'b1 || ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL div0_hold q=%h r=%0d dz=%b rdy=%b expected ffff 1234 1 1", quotient, remainder, div_zero, ready);
        end
        start_op(16'd10, 16'd3);
        tests++;
        if (div_zero !== 1'b0) begin
            fails++;
            $display("[TB] FAIL div0_clear dz=%b expected 0", div_zero);
        end
        wait_done(lat);
        tests++;
        if (quotient !== 16'd3 || remainder !== 16'd1 || div_zero !== 1'b0) begin
            fails++;
            $display("[TB] FAIL after_div0 q=%0d r=%0d dz=%b expected 3 1 0", quotient, remainder, div_zero);
        end
    endtask

    task automatic test_ignored_start();
        int lat;
        start_op(16'd200, 16'd9);
        repeat (7) @(negedge clk);
        dividend = 16'd50;
        divisor  = 16'd5;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        wait_done(lat);
        tests++;
        if (lat !== 8) begin
            fails++;
            $display("[TB] FAIL busy_start_latency got=%0d expected 8", lat);
        end
        tests++;
        if (quotient !== 16'd22 || remainder !== 16'd2) begin
            fails++;
            $display("[TB] FAIL busy_start_result q=%0d r=%0d expected 22 2", quotient, remainder);
        end
        repeat (2) @(negedge clk);
        tests++;
        if (ready !== 1'b1 || quotient !== 16'd22) begin
            fails++;
            $display("[TB] FAIL busy_start_idle rdy=%b q=%0d expected 1 22", ready, quotient);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        start_op(16'd1000, 16'd3);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if (ready !== 1'b1 || done !== 1'b0 || quotient !== 16'h0 || remainder !== 16'h0 || div_zero !== 1'b0) begin
            fails++;
            $display("[TB] FAIL mid_run_reset rdy=%b done=%b q=%h r=%h dz=%b expected 1 0 0000 0000 0",
                     ready, done, quotient, remainder, div_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_op(16'd9, 16'd4);
        wait_done(lat);
        tests++;
        if (lat !== 16 || quotient !== 16'd2 || remainder !== 16'd1) begin
            fails++;
            $display("[TB] FAIL after_reset lat=%0d q=%0d r=%0d expected 16 2 1", lat, quotient, remainder);
        end
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed();
        int lat;
        signed_op = 1'b1;
        start_op(16'hFFF9, 16'h0002);
        wait_done(lat);
        tests++;
        if (lat !== 17 || quotient !== 16'hFFFD || remainder !== 16'hFFFF) begin
            fails++;
            $display("[TB] FAIL signed_m7_2 lat=%0d q=%h r=%h expected 17 fffd ffff", lat, quotient, remainder);
        end
        start_op(16'h0007, 16'hFFFE);
        wait_done(lat);
        tests++;
        if (quotient !== 16'hFFFD || remainder !== 16'h0001) begin
            fails++;
            $display("[TB] FAIL signed_7_m2 q=%h r=%h expected fffd 0001", quotient, remainder);
        end
        start_op(16'h8000, 16'hFFFF);
        wait_done(lat);
        tests++;
        if (quotient !== 16'h8000 || remainder !== 16'h0000) begin
            fails++;
            $display("[TB] FAIL signed_min_m1 q=%h r=%h expected 8000 0000", quotient, remainder);
        end
        start_op(16'hFFF9, 16'h0000);
        wait_done(lat);
        tests++;
        if (lat !== 0 || quotient !== 16'hFFFF || remainder !== 16'hFFF9 || div_zero !== 1'b1) begin
            fails++;
            $display("[TB] FAIL signed_div0 lat=%0d q=%h r=%h dz=%b expected 0 ffff fff9 1", lat, quotient, remainder, div_zero);
        end
        signed_op = 1'b0;
        start_op(16'hFFF9, 16'h0002);
        wait_done(lat);
        tests++;
        if (lat !== 16 || quotient !== 16'h7FFC || remainder !== 16'h0001) begin
            fails++;
            $display("[TB] FAIL unsigned_mode lat=%0d q=%h r=%h expected 16 7ffc 0001", lat, quotient, remainder);
        end
    endtask
`endif

    initial begin
        tests    = 0;
        fails    = 0;
        rst_n    = 1'b1;
        start    = 1'b0;
        dividend = 16'h0;
        divisor  = 16'h0;
`ifdef DIV_SIGNED_EN
        signed_op = 1'b0;
`endif
        #2 rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_basic();
        test_boundaries();
        test_div_zero();
        test_ignored_start();
        test_reset_mid_run();
`ifdef DIV_SIGNED_EN
        test_signed();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
